reg_bus_ctrl: RTL
=================

Name: reg_bus_ctrl

Overview:
- CPU-side access controller that sits directly upstream of the register file.
- Latches a CPU read/write request and drives a stable address, write data and a one-cycle write strobe to all register instances.
- On reads, samples the OR-combined 32-bit read bus from the read-only register instances and returns it with a 4-phase ack handshake.

Parameters:
ADDR_WIDTH, 13, register address width; matches the register instances.
RD_LAT, 2, cycles from reg_addr stable to reg_rdata sampled (1..15).
TMO_CYC, 255, timeout in cycles for a read with no reg_rdy; REG_BUS_TMO_EN only (1..65535).
TMO_DATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
clk_sys  in  1  system clock
rst  in  1  reset; asynchronous assert, active-high
cpu_req  in  1  request level; held until cpu_ack seen, then dropped
cpu_rnw  in  1  1=read, 0=write; sampled with cpu_req
cpu_addr_in  in  ADDR_WIDTH  request address
cpu_wdata  in  32  write data
cpu_ack  out  1  completion; held until cpu_req falls
cpu_rdata  out  32  read data; valid while cpu_ack=1
cpu_err  out  1  access timed out; valid while cpu_ack=1
reg_addr  out  ADDR_WIDTH  registered address to all register instances
reg_wdata  out  32  registered write data
reg_wen  out  1  one-cycle write strobe
reg_ren  out  1  high for the whole read wait window
reg_rdata  in  32  OR-combined read bus from register instances
reg_rdy  in  1  any instance address hit; used only with REG_BUS_TMO_EN

Behaviour:
- Reset values: all outputs 0. FSM goes to IDLE. Latency/timeout counters are 0.
- Reset mid-transfer aborts the access; no ack is produced.
- FSM states: IDLE, WR, RD, ACK, REL.
- IDLE:
  - cpu_req=1 and cpu_ack=0 latches addr, wdata and rnw into reg_addr/reg_wdata.
  - rnw=0 goes to WR; rnw=1 goes to RD (reg_ren=1, counter cleared).
- WR: reg_wen=1 for exactly one cycle, then ACK. cpu_rdata=0, cpu_err=0.
- RD without the macro:
  - Count RD_LAT cycles.
  - On the cycle the count reaches RD_LAT, register reg_rdata into cpu_rdata, drop reg_ren, go to ACK.
  - Read latency from req accept to cpu_ack=1 is RD_LAT+2 cycles.
- ACK: cpu_ack=1, then go to REL.
- REL: cpu_ack stays 1 until cpu_req=0. On that cycle cpu_ack clears and the FSM goes to IDLE.
- cpu_rdata and cpu_err hold their values until the next access completes.
- cpu_req held high after ack never starts a second access. A new access needs cpu_req to go low and then high again.
- reg_addr holds its last value while idle. Register instances decode combinationally, so reg_addr must not change during RD.
- cpu_rnw, cpu_addr_in and cpu_wdata are ignored outside the IDLE accept cycle.

Optional Feature:
- Macro: REG_BUS_TMO_EN.
- Defined:
  - RD waits a minimum of RD_LAT cycles, then for reg_rdy=1.
  - If reg_rdy=1 when count is at least RD_LAT: sample reg_rdata, cpu_err=0.
  - If the count reaches TMO_CYC without reg_rdy: cpu_rdata=TMO_DATA, cpu_err=1, go to ACK.
  - Writes never time out.
  - The counter is 16 bits and saturates.
- Undefined:
  - reg_rdy is ignored and cpu_err is tied to 0.
  - Fixed RD_LAT behaviour as described above.
  - No timeout counter logic is present.

Decomposition:
- Shared package reg_bus_pkg holds:
  - state encoding (localparam IDLE..REL, 3 bits)
  - TMO_DATA default
  - the RD_LAT and TMO_CYC limit constants
- One natural sub-module: reg_bus_cnt, a saturating up-counter with clear, load-compare and done flag. It is used for the latency and timeout count.

Test Plan:
1. Write addr 13'h0040, data 32'h1234_5678:
   - reg_wen high for exactly 1 cycle with reg_addr=0040 and reg_wdata=12345678.
   - cpu_ack rises 2 cycles after accept; cpu_err=0.
2. Read addr 13'h0041, reg_rdata=32'h0000_00A5, RD_LAT=2:
   - cpu_ack 4 cycles after accept, cpu_rdata=000000A5.
   - reg_ren high for 3 cycles.
3. Keep cpu_req high for 10 cycles after ack:
   - Exactly one reg_wen (or one read window).
   - cpu_ack drops the cycle after cpu_req falls.
4. REG_BUS_TMO_EN, TMO_CYC=16, reg_rdy held 0:
   - cpu_ack after 18 cycles, cpu_rdata=DEADBEEF, cpu_err=1.
   - A following read with reg_rdy=1 returns cpu_err=0.
5. Assert rst during RD:
   - All outputs 0 within the same cycle, no ack.
   - After release, a read to 13'h0002 completes normally.
6. Back-to-back write then read of the same address, rdata looped to the written value 32'hCAFE_0001:
   - Read returns CAFE0001.

Source files
------------

// File: rtl/reg_bus_ctrl_pkg.sv
// reg_bus_pkg: shared constants for the register-bus access controller.
// Holds the FSM state encoding, the timeout read-data default, the legal
// ranges of the latency/timeout limits and the counter widths.
package reg_bus_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t WR   = 3'd1;
    localparam state_t RD   = 3'd2;
    localparam state_t ACK  = 3'd3;
    localparam state_t REL  = 3'd4;

    localparam logic [31:0] TMO_DATA_DEF = 32'hDEAD_BEEF;

    localparam int unsigned RD_LAT_MIN  = 1;
    localparam int unsigned RD_LAT_MAX  = 15;
    localparam int unsigned TMO_CYC_MIN = 1;
    localparam int unsigned TMO_CYC_MAX = 65535;

    // Fixed-latency reads only need to reach RD_LAT_MAX; the timeout build
    // needs the full 16-bit range.
    localparam int unsigned CNT_W_LAT = 4;
    localparam int unsigned CNT_W_TMO = 16;

    // Forces an out-of-range limit parameter into its legal window.
    function automatic int unsigned clamp_lim(input int unsigned v,
                                              input int unsigned lo,
                                              input int unsigned hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/reg_bus_ctrl_if.sv
// reg_bus_ctrl_if: CPU request/ack handshake plus the register-file bus.
// slave  : view of the access controller (accepts CPU requests, drives regs).
// master : view of the environment (CPU side and the register instances).
interface reg_bus_ctrl_if #(
    parameter int ADDR_WIDTH = 13
);
    logic                  cpu_req;
    logic                  cpu_rnw;
    logic [ADDR_WIDTH-1:0] cpu_addr_in;
    logic [31:0]           cpu_wdata;
    logic                  cpu_ack;
    logic [31:0]           cpu_rdata;
    logic                  cpu_err;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [31:0]           reg_wdata;
    logic                  reg_wen;
    logic                  reg_ren;
    logic [31:0]           reg_rdata;
    logic                  reg_rdy;

    modport slave (
        input  cpu_req, cpu_rnw, cpu_addr_in, cpu_wdata, reg_rdata, reg_rdy,
        output cpu_ack, cpu_rdata, cpu_err, reg_addr, reg_wdata, reg_wen, reg_ren
    );

    modport master (
        output cpu_req, cpu_rnw, cpu_addr_in, cpu_wdata, reg_rdata, reg_rdy,
        input  cpu_ack, cpu_rdata, cpu_err, reg_addr, reg_wdata, reg_wen, reg_ren
    );
endinterface

// File: rtl/reg_bus_ctrl_cnt.sv
// reg_bus_cnt: saturating up-counter with synchronous clear and limit compare.
// Latency: cnt updates one cycle after clr/en; done is combinational on cnt.
// Backpressure: none; holds at all-ones when en stays high.
// Ports: clk_sys/rst, clr, en, limit in; cnt value and done (cnt >= limit) out.
module reg_bus_cnt #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] cnt,
    output logic             done
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign done = (cnt_q >= limit);

endmodule

// File: rtl/reg_bus_ctrl.sv
// reg_bus_ctrl: latches a CPU read/write, drives the register bus, returns
// read data on a 4-phase req/ack handshake.
// Latency: write ack 2 cycles after accept, read ack RD_LAT+2 cycles.
// Backpressure: one access in flight; cpu_ack held until cpu_req falls, a new
// access needs cpu_req low then high again.
// Ports: clk_sys, rst (async, active-high), bus (reg_bus_ctrl_if.slave).
// Optional macro REG_BUS_TMO_EN: reads wait for reg_rdy after RD_LAT and time
// out after TMO_CYC cycles with TMO_DATA / cpu_err=1.
module reg_bus_ctrl
    import reg_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned TMO_CYC    = 255,
    parameter logic [31:0] TMO_DATA   = TMO_DATA_DEF
) (
    input  logic           clk_sys,
    input  logic           rst,
    reg_bus_ctrl_if.slave  bus
);
`ifdef REG_BUS_TMO_EN
    localparam int unsigned CNT_W = CNT_W_TMO;
`else
    localparam int unsigned CNT_W = CNT_W_LAT;
`endif
    localparam logic [CNT_W-1:0] LAT_LIM =
        CNT_W'(clamp_lim(RD_LAT, RD_LAT_MIN, RD_LAT_MAX));

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
    logic [31:0]           reg_wdata_q, reg_wdata_d;
    logic                  reg_wen_q, reg_wen_d;
    logic                  reg_ren_q, reg_ren_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic [31:0]           cpu_rdata_q, cpu_rdata_d;

    logic                  cnt_clr;
    logic                  cnt_en;
    logic [CNT_W-1:0]      cnt_val;
    logic                  lat_done;
    logic                  rd_ok;
    logic                  rd_exit;
    logic                  accept;

    // Only a fresh request is accepted; cpu_ack is always low in IDLE, the
    // term just makes the 4-phase rule explicit.
    assign accept = bus.cpu_req && !cpu_ack_q;

    reg_bus_cnt #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk_sys (clk_sys),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .limit   (LAT_LIM),
        .cnt     (cnt_val),
        .done    (lat_done)
    );

`ifdef REG_BUS_TMO_EN
    localparam logic [CNT_W-1:0] TMO_LIM =
        CNT_W'(clamp_lim(TMO_CYC, TMO_CYC_MIN, TMO_CYC_MAX));

    logic cpu_err_q, cpu_err_d;
    logic rd_tmo;

    // A ready hit wins over a timeout landing on the same cycle.
    assign rd_ok   = lat_done && bus.reg_rdy;
    assign rd_tmo  = !rd_ok && (cnt_val >= TMO_LIM);
    assign rd_exit = rd_ok || rd_tmo;
`else
    logic unused_tmo;

    assign rd_ok      = lat_done;
    assign rd_exit    = lat_done;
    assign unused_tmo = ^{bus.reg_rdy, TMO_DATA, TMO_CYC[15:0], cnt_val};
`endif

    // State register and all output flops.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_wen_q   <= 1'b0;
            reg_ren_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
`ifdef REG_BUS_TMO_EN
            cpu_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wen_q   <= reg_wen_d;
            reg_ren_q   <= reg_ren_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
`ifdef REG_BUS_TMO_EN
            cpu_err_q   <= cpu_err_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = bus.cpu_rnw ? RD : WR;
            WR:   state_d = ACK;
            RD:   if (rd_exit) state_d = ACK;
            ACK:  state_d = REL;
            REL:  if (!bus.cpu_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic.
    always_comb begin
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wen_d   = 1'b0;
        reg_ren_d   = reg_ren_q;
        cpu_ack_d   = cpu_ack_q;
        cpu_rdata_d = cpu_rdata_q;
`ifdef REG_BUS_TMO_EN
        cpu_err_d   = cpu_err_q;
`endif
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    reg_addr_d  = bus.cpu_addr_in;
                    reg_wdata_d = bus.cpu_wdata;
                    if (bus.cpu_rnw) begin
                        reg_ren_d = 1'b1;
                        cnt_clr   = 1'b1;
                    end else begin
                        reg_wen_d = 1'b1;
                    end
                end
            end
            WR: begin
                cpu_rdata_d = '0;
`ifdef REG_BUS_TMO_EN
                cpu_err_d   = 1'b0;
`endif
            end
            RD: begin
                cnt_en = 1'b1;
                if (rd_ok) begin
                    cpu_rdata_d = bus.reg_rdata;
                    reg_ren_d   = 1'b0;
`ifdef REG_BUS_TMO_EN
                    cpu_err_d   = 1'b0;
                end else if (rd_tmo) begin
                    cpu_rdata_d = TMO_DATA;
                    cpu_err_d   = 1'b1;
                    reg_ren_d   = 1'b0;
`endif
                end
            end
            ACK: cpu_ack_d = 1'b1;
            REL: if (!bus.cpu_req) cpu_ack_d = 1'b0;
            default: ;
        endcase
    end

    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_wen   = reg_wen_q;
    assign bus.reg_ren   = reg_ren_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
`ifdef REG_BUS_TMO_EN
    assign bus.cpu_err   = cpu_err_q;
`else
    assign bus.cpu_err   = 1'b0;
`endif

endmodule
